seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Memory-mapped 7-segment scan controller; next generation of the board's digit driver.
//  CPU writes a value, display mode and blank mask over the IO bus.
//  Block time-multiplexes NUM_DIGITS digits (hex, or decimal via sequential binary->BCD).
//  Scan runs as a clock-enable tick, no derived clocks. Sits between MMIO decode and board pins.
// PARAMETERS
//  NUM_DIGITS  8      digits scanned; even, 2..8; lower half on seg_lo, upper half on seg_hi
//  SCAN_DIV    50000  clk cycles per digit slot (>=2); use 4 in simulation
//  DATA_W      32     width of written value; decimal mode converts all DATA_W bits
// PORTS
//  clk      in   1           system clock
//  rst      in   1           synchronous, active-high reset
//  wr_en    in   1           IO write strobe, one cycle per write
//  wr_addr  in   2           0=VALUE, 1=MODE, 2=BLANK_MASK, 3=ignored
//  wr_data  in   DATA_W      write data
//  busy     out  1           decimal conversion in progress
//  ovf      out  1           last decimal value >= 10^NUM_DIGITS (display shows value mod 10^N)
//  an       out  NUM_DIGITS  digit select, one-hot, active high
//  seg_lo   out  8           segments for digits 0..N/2-1; {a,b,c,d,e,f,g,dp}, active high
//  seg_hi   out  8           segments for digits N/2..N-1, same encoding
// BEHAVIOUR
//  Reset: an=0, seg_lo=0, seg_hi=0, busy=0, ovf=0. VALUE, MODE, mask, display buffer,
//   scan counter and digit index all clear.
//  MODE bits: [0] dec (1=decimal, 0=hex); [1] lzs (leading-zero suppress). Other bits ignored.
//  Font: 0..F = fc 60 da f2 66 b6 be e0 fe f6 ee 3e 9c 7a 9e 8e. Blank = 8'h00.
//  Hex path: VALUE write with dec=0 loads display buffer (low 4*N bits) the next cycle; ovf=0.
//  Decimal path: VALUE write with dec=1 sets busy the next cycle.
//   Shift-add-3 runs for DATA_W cycles, one bit per cycle, MSB first, on a 4*N-bit BCD register.
//   Carry out of the top digit sets a sticky ovf_pend.
//   On the final cycle, the buffer and ovf are loaded together and busy drops the next cycle.
//   Total: busy high exactly DATA_W cycles.
//  Write to VALUE while busy: conversion restarts with the new value; the old result is discarded.
//   The display buffer keeps its previous contents until the restarted conversion completes.
//  MODE write: affects the next VALUE write only; no reconversion.
//   lzs and mask apply immediately at render time.
//  BLANK_MASK write: bit i=1 forces digit i blank. Takes effect on the next scan slot.
//  lzs=1: digits above the most-significant non-zero digit are blank.
//   Digit 0 is never suppressed by lzs (value 0 shows "0"). The mask overrides lzs.
//  Scan:
//   - Counter 0..SCAN_DIV-1; tick when count == SCAN_DIV-1.
//   - On tick, digit index advances and wraps N-1 -> 0.
//   - Outputs are registered: an/seg update on the cycle after the index changes.
//   - Active bus carries the glyph; the other bus is driven 8'h00.
//   - an = 1 << index, always one-hot after the first tick. No latches; all paths fully assigned.
//  Simultaneous wr_en and tick: both take effect; the digit rendered uses the buffer before the write.
//  Reset mid-conversion: busy=0 and ovf=0 next cycle; the result is lost.
// STRUCTURE
//  seg7_pkg:
//   - register address localparams: ADDR_VALUE, ADDR_MODE, ADDR_MASK
//   - MODE bit indices
//   - function seg7_font(input [3:0]) -> [7:0]
//   - SEG_BLANK constant
//  Sub-module bin2bcd_seq (DATA_W, NUM_DIGITS):
//   - ports: start, bin, busy, done, bcd, ovf
//   - owns the shift-add-3 FSM (IDLE -> SHIFT x DATA_W -> DONE -> IDLE)
//  Top level holds the register file, scan counter/index, lzs/mask logic and output registers.
// TESTING
//  (SCAN_DIV=4, N=8, DATA_W=32)
//  1. Hex: MODE=0, VALUE=0x1234ABCD
//     -> an=8'h01 with seg_lo=8'h7a, seg_hi=0.
//     -> an=8'h80 with seg_hi=8'h60; full 8-digit cycle takes 32 clk.
//  2. Decimal: MODE=1, VALUE=12345678
//     -> busy high exactly 32 cycles, ovf=0.
//     -> digits 7..0 show 1..8 (digit0 seg_lo=8'hfe).
//  3. Overflow: MODE=1, VALUE=100000123
//     -> ovf=1; digits show 00000123 (digit2 = 8'h60, digit7 = 8'hfc).
//  4. LZS + mask: MODE=2, VALUE=0x50, mask=8'h01
//     -> digits 2..7 blank (8'h00).
//     -> digit1 = 8'hb6; digit0 blank by mask.
//     -> VALUE=0 with mask=0 gives digit0 = 8'hfc.
//  5. Restart: decimal write 999, another write 42 at busy cycle 10
//     -> busy total 42 cycles; buffer never shows 999; final shows 42.
//  6. Reset: rst at busy cycle 5
//     -> next cycle busy=0, ovf=0, an=0, seg_lo=seg_hi=0; scan resumes from digit 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and the segment font for the 7-segment scan controller.
package seg7_pkg;

  localparam logic [1:0] ADDR_VALUE = 2'd0;
  localparam logic [1:0] ADDR_MODE  = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;

  localparam int MODE_DEC = 0;
  localparam int MODE_LZS = 1;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Segment order {a,b,c,d,e,f,g,dp}, active high
  function automatic logic [7:0] seg7_font(input logic [3:0] d);
    logic [7:0] s;
    unique case (d)
      4'h0: s = 8'hfc;
      4'h1: s = 8'h60;
      4'h2: s = 8'hda;
      4'h3: s = 8'hf2;
      4'h4: s = 8'h66;
      4'h5: s = 8'hb6;
      4'h6: s = 8'hbe;
      4'h7: s = 8'he0;
      4'h8: s = 8'hfe;
      4'h9: s = 8'hf6;
      4'ha: s = 8'hee;
      4'hb: s = 8'h3e;
      4'hc: s = 8'h9c;
      4'hd: s = 8'h7a;
      4'he: s = 8'h9e;
      4'hf: s = 8'h8e;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per cycle.
module bin2bcd_seq #(
  parameter int DATA_W     = 32,
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic [BW-1:0]     adj;
  logic [BW-1:0]     shifted;
  logic              carry;
  logic              last;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shifted = {adj[BW-2:0], sr_q[DATA_W-1]};
    carry   = adj[BW-1];
  end

  assign last = (state_q == S_SHIFT) &&
                (cnt_q == CW'(DATA_W - 1));

  // Result is presented on the final shift cycle; a restart suppresses it
  assign busy = (state_q == S_SHIFT);
  assign done = last && !start;
  assign bcd  = shifted;
  assign ovf  = ovf_q | carry;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (start) begin
      state_d = S_SHIFT;
      sr_d    = bin;
      bcd_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_SHIFT: begin
          sr_d  = sr_q << 1;
          bcd_d = shifted;
          ovf_d = ovf_q | carry;
          cnt_d = cnt_q + 1'b1;
          if (last)
            state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Memory-mapped 7-segment scan controller: register file, conversion,
// digit scan with leading-zero suppress and blank mask.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [1:0]            wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  busy,
  output logic                  ovf,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            seg_lo,
  output logic [7:0]            seg_hi
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] HALF = IW'(NUM_DIGITS / 2);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

  logic [1:0]            mode_q, mode_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [BW-1:0]         buf_q, buf_d;
  logic                  ovf_q, ovf_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            lo_q, lo_d;
  logic [7:0]            hi_q, hi_d;

  logic          start;
  logic          cv_done;
  logic          cv_ovf;
  logic [BW-1:0] cv_bcd;
  logic          tick;
  logic [IW-1:0] msnz;
  logic          blank;
  logic [7:0]    glyph;

  bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_cvt (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (wr_data),
    .busy  (busy),
    .done  (cv_done),
    .bcd   (cv_bcd),
    .ovf   (cv_ovf)
  );

  always_comb begin
    mode_d = mode_q;
    mask_d = mask_q;
    buf_d  = buf_q;
    ovf_d  = ovf_q;
    start  = 1'b0;
    if (cv_done) begin
      buf_d = cv_bcd;
      ovf_d = cv_ovf;
    end
    if (wr_en) begin
      unique case (wr_addr)
        ADDR_VALUE: begin
          if (mode_q[MODE_DEC]) begin
            start = 1'b1;
          end else begin
            buf_d = BW'(wr_data);
            ovf_d = 1'b0;
          end
        end
        ADDR_MODE: mode_d = {wr_data[MODE_LZS], wr_data[MODE_DEC]};
        ADDR_MASK: mask_d = wr_data[NUM_DIGITS-1:0];
        default: ;
      endcase
    end
  end

  // Render the current digit from the pre-write buffer
  always_comb begin
    msnz = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (buf_q[4*i +: 4] != 4'd0)
        msnz = IW'(i);
    end
    blank = mask_q[idx_q] ||
            (mode_q[MODE_LZS] && (idx_q > msnz));
    glyph = blank ? SEG_BLANK :
            seg7_font(buf_q[{idx_q, 2'b00} +: 4]);
  end

  assign tick = (cnt_q == CW'(SCAN_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    an_d  = an_q;
    lo_d  = lo_q;
    hi_d  = hi_q;
    if (tick) begin
      cnt_d = '0;
      idx_d = (idx_q == LAST) ? '0 : idx_q + 1'b1;
      an_d  = NUM_DIGITS'(1) << idx_q;
      lo_d  = (idx_q < HALF) ? glyph : SEG_BLANK;
      hi_d  = (idx_q < HALF) ? SEG_BLANK : glyph;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= '0;
      mask_q <= '0;
      buf_q  <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      idx_q  <= '0;
      an_q   <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
    end else begin
      mode_q <= mode_d;
      mask_q <= mask_d;
      buf_q  <= buf_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      lo_q   <= lo_d;
      hi_q   <= hi_d;
    end
  end

  assign ovf    = ovf_q;
  assign an     = an_q;
  assign seg_lo = lo_q;
  assign seg_hi = hi_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: vector table plus
// restart and reset sequences, scan outputs checked via a scoreboard.
module tb_seg7_scan_ctrl;

  localparam int N  = 8;
  localparam int SD = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [1:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          ovf;
  logic [N-1:0]  an;
  logic [7:0]    seg_lo;
  logic [7:0]    seg_hi;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS (N),
    .SCAN_DIV   (SD),
    .DATA_W     (DW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .ovf     (ovf),
    .an      (an),
    .seg_lo  (seg_lo),
    .seg_hi  (seg_hi)
  );

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] lo;
    logic [7:0] hi;
  } exp_t;

  typedef struct {
    logic [1:0]       mode;
    logic [31:0]      value;
    logic [7:0]       mask;
    logic [7:0][7:0]  seg;
    logic             ovf;
  } vec_t;

  exp_t sb[$];
  vec_t vt[7];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int saw9     = 0;
  logic watch9 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (watch9 && (seg_lo == 8'hf6 || seg_hi == 8'hf6))
      saw9 <= saw9 + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0][7:0] seg);
    exp_t e;
    for (int d = 0; d < N; d++) begin
      e.an = 8'(1 << d);
      e.lo = (d < N/2) ? seg[d] : 8'h00;
      e.hi = (d < N/2) ? 8'h00 : seg[d];
      sb.push_back(e);
    end
  endtask

  // kind 1: rewrite VALUE=42 in busy cycle 10; kind 2: reset in busy cycle 5
  task automatic run_busy(input int kind, output int n);
    int g;
    n = 0;
    g = 0;
    while (busy && g < 300) begin
      n++;
      if (kind == 1 && n == 10) begin
        wr_en   = 1'b1;
        wr_addr = 2'd0;
        wr_data = 32'd42;
      end else begin
        wr_en = 1'b0;
      end
      if (kind == 2 && n == 5)
        rst = 1'b1;
      @(negedge clk);
      g++;
    end
    wr_en = 1'b0;
  endtask

  task automatic scan_check(input string tag);
    logic [7:0] prev;
    int g;
    int t0;
    exp_t e;
    prev = an;
    g = 0;
    while (!(an == 8'h01 && prev != 8'h01) && g < 200) begin
      prev = an;
      @(negedge clk);
      g++;
    end
    if (g >= 200) chk({tag, " sync timeout"}, g, 0);
    t0 = cyc;
    for (int k = 0; k < N; k++) begin
      if (k > 0) begin
        prev = an;
        g = 0;
        while (an == prev && g < 20) begin
          @(negedge clk);
          g++;
        end
      end
      e = sb.pop_front();
      chk($sformatf("%s d%0d", tag, k),
          {8'h00, an, seg_lo, seg_hi}, {8'h00, e.an, e.lo, e.hi});
    end
    prev = an;
    g = 0;
    while (an == prev && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk({tag, " period"}, cyc - t0, 32);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int g;

    vt[0] = '{2'd0, 32'h1234ABCD, 8'h00,
              {8'h60, 8'hda, 8'hf2, 8'h66,
               8'hee, 8'h3e, 8'h9c, 8'h7a}, 1'b0};
    vt[1] = '{2'd1, 32'd12345678, 8'h00,
              {8'h60, 8'hda, 8'hf2, 8'h66,
               8'hb6, 8'hbe, 8'he0, 8'hfe}, 1'b0};
    vt[2] = '{2'd1, 32'd100000123, 8'h00,
              {8'hfc, 8'hfc, 8'hfc, 8'hfc,
               8'hfc, 8'h60, 8'hda, 8'hf2}, 1'b1};
    vt[3] = '{2'd2, 32'h50, 8'h01,
              {8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'hb6, 8'h00}, 1'b0};
    vt[4] = '{2'd2, 32'h0, 8'h00,
              {8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'hfc}, 1'b0};
    vt[5] = '{2'd0, 32'hFEDC0000, 8'h80,
              {8'h00, 8'h9e, 8'h7a, 8'h9c,
               8'hfc, 8'hfc, 8'hfc, 8'hfc}, 1'b0};
    vt[6] = '{2'd3, 32'd7, 8'h00,
              {8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00, 8'h00, 8'he0}, 1'b0};

    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = 2'd0;
    wr_data = '0;
    repeat (3) @(negedge clk);
    chk("reset outs", {6'd0, an, seg_lo, seg_hi, busy, ovf}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("an before tick", an, 0);

    for (int i = 0; i < 7; i++) begin
      wr(2'd1, {30'd0, vt[i].mode});
      wr(2'd2, {24'd0, vt[i].mask});
      push_exp(vt[i].seg);
      wr(2'd0, vt[i].value);
      if (vt[i].mode[0]) begin
        run_busy(0, n);
        chk($sformatf("v%0d busy cycles", i), n, 32);
      end
      chk($sformatf("v%0d ovf", i), ovf, vt[i].ovf);
      scan_check($sformatf("v%0d", i));
    end

    watch9 = 1'b1;
    wr(2'd1, 32'd1);
    wr(2'd2, 32'd0);
    push_exp({8'hfc, 8'hfc, 8'hfc, 8'hfc,
              8'hfc, 8'hfc, 8'h66, 8'hda});
    wr(2'd0, 32'd999);
    run_busy(1, n);
    chk("restart busy cycles", n, 42);
    chk("restart ovf", ovf, 0);
    scan_check("restart");
    watch9 = 1'b0;
    chk("restart no 999 shown", saw9, 0);

    wr(2'd0, 32'd100000123);
    run_busy(0, n);
    chk("pre-reset ovf", ovf, 1);
    wr(2'd0, 32'd12345678);
    run_busy(2, n);
    chk("reset busy cycle", n, 5);
    chk("mid-conv reset outs",
        {6'd0, an, seg_lo, seg_hi, busy, ovf}, 0);
    rst = 1'b0;
    g = 0;
    while (an == 8'h00 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("first slot delay", g, 4);
    chk("resume digit0", {an, seg_lo, seg_hi}, {8'h01, 8'hfc, 8'h00});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
